// File: rtl/regfile_dump.sv
// Register-file read-out engine: sweeps an inclusive index range and
// streams each register value, tagged with its index, over valid/ready.
module regfile_dump #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [4:0]   first,
    input  logic [4:0]   last,
    output logic [4:0]   ra,
    input  logic [N-1:0] rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [4:0]   out_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        VALID
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [4:0] idx;
    logic [4:0] last_q;
    logic       fin;

    // Final handshake: the word on the output is the last of the range
    assign fin = out_valid && out_ready && (out_idx == last_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    state_nx = VALID;
            VALID:   if (fin) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        ra   = idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            last_q    <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= first;
                        last_q <= last;
                    end
                end
                READ: begin
                    out_data  <= rd;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                    idx       <= idx + 5'd1;
                end
                VALID: begin
                    if (fin) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else if (out_ready) begin
                        out_data <= rd;
                        out_idx  <= idx;
                        idx      <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file
// whose entry 31 reads as zero.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first;
    logic [4:0]  last;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;

    logic [63:0] rf [32];
    int          n_cmp = 0;
    int          n_err = 0;

    regfile_dump #(.N(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .first    (first),
        .last     (last),
        .ra       (ra),
        .rd       (rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign rd = (ra == 5'd31) ? 64'd0 : rf[ra];

    function automatic logic [63:0] exp_val(input logic [4:0] i);
        return (i == 5'd31) ? 64'd0 : rf[i];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        @(negedge clk);
        start = 1'b1;
        first = f;
        last  = l;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic sweep(input logic [4:0] f, input logic [4:0] l,
                         input bit bp, input bit poke);
        int          n;
        int          got;
        int          last_cyc;
        logic [4:0]  e;
        logic [4:0]  diff;
        bit          pv;
        bit          pr;
        logic [63:0] pd;
        logic [4:0]  pix;
        bit          pat [6];
        pat      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        diff     = l - f;
        n        = int'(diff) + 1;
        got      = 0;
        last_cyc = 0;
        e        = f;
        pv       = 1'b0;
        pr       = 1'b0;
        pd       = '0;
        pix      = '0;
        do_start(f, l);
        for (int c = 1; c <= 200 && got < n; c++) begin
            @(negedge clk);
            if (poke) begin
                start = (c == 5);
                first = 5'd10;
                last  = 5'd12;
            end
            if (pv && !pr) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, pd);
                check("hold_idx", 64'(out_idx), 64'(pix));
            end
            out_ready = (bp && c <= 6) ? pat[c-1] : 1'b1;
            if (out_valid && out_ready) begin
                check("xfer_idx", 64'(out_idx), 64'(e));
                check("xfer_data", out_data, exp_val(e));
                e        = e + 5'd1;
                got++;
                last_cyc = c;
            end
            pv  = out_valid;
            pr  = out_ready;
            pd  = out_data;
            pix = out_idx;
        end
        start = 1'b0;
        check("word_count", 64'(got), 64'(n));
        if (!bp) check("latency", 64'(last_cyc), 64'(n));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'(i) * 64'h0101_0101_0101_0101;
        reset     = 1'b1;
        start     = 1'b0;
        first     = '0;
        last      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ra", 64'(ra), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        reset = 1'b0;

        sweep(5'd0, 5'd31, 1'b0, 1'b0);
        sweep(5'd3, 5'd5, 1'b1, 1'b0);
        sweep(5'd30, 5'd1, 1'b0, 1'b0);
        sweep(5'd7, 5'd7, 1'b0, 1'b0);
        sweep(5'd0, 5'd31, 1'b0, 1'b1);

        out_ready = 1'b0;
        do_start(5'd5, 5'd6);
        @(negedge clk);
        check("cw_idx5", 64'(out_idx), 64'd5);
        check("cw_data5", out_data, 64'h0505_0505_0505_0505);
        rf[5] = 64'hDEAD;
        rf[6] = 64'hBEEF;
        @(negedge clk);
        check("cw_keep5", out_data, 64'h0505_0505_0505_0505);
        out_ready = 1'b1;
        @(negedge clk);
        check("cw_idx6", 64'(out_idx), 64'd6);
        check("cw_data6", out_data, 64'hBEEF);
        @(negedge clk);
        check("cw_done", 64'(done), 64'd1);
        rf[5] = 64'(5) * 64'h0101_0101_0101_0101;
        rf[6] = 64'(6) * 64'h0101_0101_0101_0101;

        do_start(5'd0, 5'd31);
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_idx == 5'd3) break;
        end
        check("rst_reach", 64'(out_idx), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_done", 64'(done), 64'd0);
        check("mid_ra", 64'(ra), 64'd0);
        sweep(5'd0, 5'd2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for the 32 x 64-bit register file. On a start pulse it sweeps the register-file read port over an inclusive index range and streams each register value, tagged with its index, onto a valid/ready output. It is the reader on the register file's ports, used for debug dumps, end-of-program state checks and self-checking benches. It never writes the register file.

## Interface
Parameters:
- N, 64, data width; matches register-file word width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; sampled only in IDLE.
- first  in  5  first register index; sampled with start.
- last  in  5  last register index; sampled with start.
- ra  out  5  read address to the register file (drives ra1 or ra2).
- rd  in  N  read data from the register file; combinational function of ra.
- out_valid  out  1  out_data/out_idx hold a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  N  captured register value.
- out_idx  out  5  index of out_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- State is IDLE, READ or VALID. Registers are idx[4:0] (next index to read), last_q[4:0], out_data, out_idx, out_valid and done. ra = idx at all times.
- IDLE: when start=1, load idx<=first and last_q<=last, then go to READ. When start=0, stay in IDLE.
- READ: out_data<=rd, out_idx<=idx, out_valid<=1, idx<=idx+1 (mod 32), then go to VALID.
- VALID with out_ready=0: hold all outputs and idx.
- VALID with out_ready=1 and out_idx==last_q: out_valid<=0, done<=1, go to IDLE.
- VALID with out_ready=1 and out_idx!=last_q: out_data<=rd, out_idx<=idx, idx<=idx+1, stay in VALID. This gives back-to-back transfers at one word per cycle.
- Index arithmetic is 5-bit and wraps 31->0.
  - If first>last, the sweep wraps. Example: first=30, last=1 reads 30, 31, 0, 1.
  - If first==last, exactly one word is read.
  - A sweep always reads ((last-first) mod 32)+1 words.
- No special casing of indices. The register-file read data is streamed unchanged, including index 31 (reads zero) and index 0.
- out_data is a captured copy. A register-file write to a register already captured does not change out_data. A write to a register not yet read is seen when that register is read.
- start while busy is ignored, and first/last are not resampled.

## Timing
- Reset values: state=IDLE, idx=0, last_q=0, ra=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0.
- Reset asserted mid-sweep: at the next edge all registers return to their reset values. No done pulse is produced and the in-flight word is dropped.
- Start latency: start sampled at edge t puts the block in READ during cycle t..t+1. out_valid=1 and the first word are visible after edge t+1.
- busy goes high after edge t. It stays high through the edge at which the final handshake occurs.
- A transfer occurs on an edge where out_valid=1 and out_ready=1.
- While out_valid=1 and out_ready=0, out_data and out_idx are stable.
- out_valid never drops without a handshake, except on reset.
- done is high for exactly the one cycle after the final transfer edge, concurrent with busy=0. A start presented in that cycle is accepted.
- With out_ready held at 1, an n-word sweep occupies n+1 cycles from the start edge to the done edge.

## Test plan
- Full sweep, no backpressure. Preload X_i=i·0x0101_0101_0101_0101 for i in 0..30; X31 reads 0. Apply start, first=0, last=31, out_ready=1. Expect 32 consecutive transfers with out_idx 0..31 and matching data (index 31 gives 0), then done for 1 cycle and busy low.
- Backpressure. Apply first=3, last=5 with out_ready toggling 0,0,1,0,1,1. Expect out_data/out_idx stable while ready=0, exactly 3 transfers (3, 4, 5) in order, no duplicates, then done.
- Wrap and single word. first=30, last=1 gives indices 30, 31, 0, 1, then done. first=last=7 gives one transfer, X7, then done in the following cycle.
- Start while busy. Pulse start with first=10, last=12 during a 0..31 sweep. It is ignored: the sweep still ends at 31 with exactly 32 words.
- Concurrent write. With X5 captured and ready=0, write X5=0xDEAD and X6=0xBEEF. Expect out_data still old X5; the next word is idx 6 with 0xBEEF.
- Reset mid-sweep. Assert reset during transfer 4 of a 0..31 sweep. Next cycle expect out_valid=0, busy=0, done=0, ra=0. A fresh start then produces index 0 again.
